// File: rtl/uart_tx_param.sv
// uart_tx_param: UART transmitter with an input FIFO and valid/ready handshake.
// Serialises DATA_W-bit words into start/data/[parity]/stop frames, back to back
// when words are queued. Optional parity bit is enabled by defining
// UART_TX_PARITY_EN (adds the parity_odd port and a parity bit after the data).
module uart_tx_param #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 435,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned MSB_FIRST    = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            s_valid,
  input  logic [DATA_W-1:0]               s_data,
  output logic                            s_ready,
`ifdef UART_TX_PARITY_EN
  input  logic                            parity_odd,
`endif
  output logic                            tx,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW  = $clog2(DATA_W);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0]  DataLast = IdxW'(DATA_W - 1);
  localparam logic [IdxW-1:0]  StopLast = IdxW'(STOP_BITS - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              push, pop, empty;
  logic [DATA_W-1:0] head;

  assign s_ready    = (count_q != CntFull);
  assign push       = s_valid && s_ready;
  assign empty      = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  // FIFO storage; contents need no reset since count_q gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame serialiser
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              bit_end, load, out_bit;
  logic [DATA_W-1:0] sh_next;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign bit_end = (baud_q == BaudLast);
  // The shift register always presents the next data bit at one fixed end
  assign out_bit = (MSB_FIRST != 0) ? sh_q[DATA_W-1] : sh_q[0];
  assign sh_next = (MSB_FIRST != 0) ? {sh_q[DATA_W-2:0], 1'b0} : {1'b0, sh_q[DATA_W-1:1]};

  // Serialiser state, baud/bit counters and registered line outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state: tx_d is the value the line holds for the whole upcoming bit
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    load    = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!empty) load = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
          tx_d    = out_bit;
          sh_d    = sh_next;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == DataLast) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = par_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = out_bit;
            sh_d  = sh_next;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (idx_q == StopLast) begin
            done_d = 1'b1;
            // Chain straight into the next frame when a word is waiting
            if (!empty) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // Pop the head word and drive the start bit on the same edge
    if (load) begin
      pop     = 1'b1;
      sh_d    = head;
      state_d = StStart;
      tx_d    = 1'b0;
      baud_d  = '0;
      idx_d   = '0;
`ifdef UART_TX_PARITY_EN
      par_d   = (^head) ^ parity_odd;
`endif
    end
  end

  assign tx   = tx_q;
  assign done = done_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: two uart_tx_param instances (LSB-first/1 stop and
// MSB-first/2 stop) checked cycle by cycle against a waveform-queue model.
module tb_uart_tx_param;

  localparam int CPB   = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        par_sel;
  logic [1:0]  s_ready, tx, busy, done;
  logic [2:0]  cnt0, cnt1;

  int total = 0;
  int bad   = 0;

  // Reference model state: pending words and the expected future tx waveform
  logic [7:0] mq [2][$];
  bit         mw [2][$];
  bit         active  [2];
  logic       exp_tx  [2];
  logic       exp_busy[2];
  logic       exp_done[2];
  logic       exp_rdy [2];
  int         exp_cnt [2];

  always #5 clk = ~clk;

  uart_tx_param #(
    .DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .MSB_FIRST(0)
  ) u_lsb (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready[0]),
`ifdef UART_TX_PARITY_EN
    .parity_odd(par_sel),
`endif
    .tx(tx[0]), .busy(busy[0]), .done(done[0]), .fifo_count(cnt0)
  );

  uart_tx_param #(
    .DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1)
  ) u_msb (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready[1]),
`ifdef UART_TX_PARITY_EN
    .parity_odd(par_sel),
`endif
    .tx(tx[1]), .busy(busy[1]), .done(done[1]), .fifo_count(cnt1)
  );

  function automatic int nstop(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic bit msb_first(input int d);
    return d != 0;
  endfunction

  task automatic check(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, d, $time, obs, expv);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      check("tx", d, 32'(tx[d]), 32'(exp_tx[d]));
      check("busy", d, 32'(busy[d]), 32'(exp_busy[d]));
      check("done", d, 32'(done[d]), 32'(exp_done[d]));
      check("s_ready", d, 32'(s_ready[d]), 32'(exp_rdy[d]));
      check("fifo_count", d, (d == 0) ? 32'(cnt0) : 32'(cnt1), 32'(exp_cnt[d]));
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      mw[d].delete();
      active[d]   = 1'b0;
      exp_tx[d]   = 1'b1;
      exp_busy[d] = 1'b0;
      exp_done[d] = 1'b0;
      exp_rdy[d]  = 1'b1;
      exp_cnt[d]  = 0;
    end
  endtask

  task automatic push_bit(input int d, input bit v);
    for (int c = 0; c < CPB; c++) mw[d].push_back(v);
  endtask

  // One clock edge of the model, using input values present before the edge
  task automatic model_edge(input int d);
    bit         accept;
    logic [7:0] w;
    accept      = s_valid && (mq[d].size() < DEPTH);
    exp_done[d] = 1'b0;
    if (mw[d].size() == 0) begin
      if (active[d]) begin
        exp_done[d] = 1'b1;
        active[d]   = 1'b0;
      end
      if (mq[d].size() != 0) begin
        w = mq[d].pop_front();
        active[d] = 1'b1;
        push_bit(d, 1'b0);
        for (int k = 0; k < DW; k++) push_bit(d, msb_first(d) ? w[DW-1-k] : w[k]);
`ifdef UART_TX_PARITY_EN
        push_bit(d, (^w) ^ par_sel);
`endif
        for (int s = 0; s < nstop(d); s++) push_bit(d, 1'b1);
      end
    end
    if (accept) mq[d].push_back(s_data);
    exp_tx[d]   = (mw[d].size() != 0) ? mw[d].pop_front() : 1'b1;
    exp_busy[d] = active[d];
    exp_cnt[d]  = mq[d].size();
    exp_rdy[d]  = (mq[d].size() < DEPTH);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] v);
    s_valid = 1'b1;
    s_data  = v;
    cycle();
    s_valid = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    par_sel = 1'b0;
    model_reset();
    repeat (3) cycle();
    #3 reset = 1'b0;

    // Idle after reset
    repeat (20) cycle();

    // Directed frames
    send(8'hA5);
    repeat (60) cycle();
    send(8'h31);
    repeat (60) cycle();
    par_sel = 1'b0;
    send(8'h07);
    repeat (60) cycle();
    par_sel = 1'b1;
    send(8'h07);
    repeat (60) cycle();

    // Burst of six words: FIFO fills and frames run back to back
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      cycle();
    end
    s_valid = 1'b0;
    repeat (300) cycle();

    // Random traffic including full-FIFO pushes
    for (int i = 0; i < 400; i++) begin
      s_valid = ($urandom_range(0, 4) == 0);
      s_data  = 8'($urandom);
      par_sel = 1'($urandom_range(0, 1));
      cycle();
    end
    s_valid = 1'b0;
    repeat (300) cycle();

    // Reset during the third data bit with two words queued
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      cycle();
    end
    s_valid = 1'b0;
    repeat (11) cycle();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    repeat (3) cycle();
    #3 reset = 1'b0;
    repeat (100) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
